// File: rtl/rll_key_loader.sv
// Serial key loader for RLL-locked netlists: shifts a parity-protected key in over a
// valid/ready bit stream and exposes it on key_out only once it has been verified.
`timescale 1ns/1ps

module rll_key_loader #(
   parameter int KEY_W        = 16,
   parameter int TIMEOUT      = 64,
   parameter int MAX_FAIL     = 3,
   parameter bit ALLOW_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             zeroize,
   input  logic             ser_data,
   input  logic             ser_valid,
   output logic             ser_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             load_err,
   output logic             lockout,
   output logic             busy
);

   localparam int CNT_W  = $clog2(KEY_W + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam int FAIL_W = $clog2(MAX_FAIL + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_LOCKED,
      ST_ERROR,
      ST_LOCKOUT
   } state_t;

   state_t              state_q, state_d;
   logic [KEY_W-1:0]    shadow_q, shadow_d;
   logic                parity_q, parity_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic                key_valid_q, key_valid_d;
   logic                load_err_q, load_err_d;
   logic                lockout_q, lockout_d;
   logic                ser_ready_q, ser_ready_d;
   logic                busy_q, busy_d;

   logic                accept;
   logic                start_evt;
   logic                fail_evt;
   logic [FAIL_W-1:0]   fail_inc;

   assign accept   = ser_valid && ser_ready_q;
   assign fail_inc = fail_cnt_q + FAIL_W'(1);

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      parity_d    = parity_q;
      bit_cnt_d   = bit_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      load_err_d  = load_err_q;
      start_evt   = 1'b0;
      fail_evt    = 1'b0;

      // zeroize wins over everything except a lockout, and never touches fail_cnt
      if (zeroize && (state_q != ST_LOCKOUT)) begin
         state_d     = ST_IDLE;
         key_d       = '0;
         key_valid_d = 1'b0;
         load_err_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_start) start_evt = 1'b1;
            end
            ST_SHIFT: begin
               if (accept) begin
                  tmo_cnt_d = '0;
                  if (bit_cnt_q < CNT_W'(KEY_W)) begin
                     for (int i = 0; i < KEY_W; i++) begin
                        if (bit_cnt_q == CNT_W'(i)) shadow_d[i] = ser_data;
                     end
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end else begin
                     parity_d = ser_data;
                     state_d  = ST_CHECK;
                  end
               end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                  fail_evt = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
            end
            ST_CHECK: begin
               if ((^shadow_q ^ parity_q) == 1'b0) begin
                  key_d       = shadow_q;
                  key_valid_d = 1'b1;
                  fail_cnt_d  = '0;
                  state_d     = ST_LOCKED;
               end else begin
                  fail_evt = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (ALLOW_RELOAD && load_start) begin
                  key_d       = '0;
                  key_valid_d = 1'b0;
                  start_evt   = 1'b1;
               end
            end
            ST_ERROR: begin
               if (load_start) start_evt = 1'b1;
            end
            ST_LOCKOUT: begin
               state_d = ST_LOCKOUT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         if (start_evt) begin
            state_d    = ST_SHIFT;
            bit_cnt_d  = '0;
            shadow_d   = '0;
            tmo_cnt_d  = '0;
            load_err_d = 1'b0;
         end

         if (fail_evt) begin
            load_err_d = 1'b1;
            fail_cnt_d = fail_inc;
            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
               state_d     = ST_LOCKOUT;
               key_d       = '0;
               key_valid_d = 1'b0;
            end else begin
               state_d = ST_ERROR;
            end
         end
      end

      // status outputs are registered copies of the next state
      ser_ready_d = (state_d == ST_SHIFT);
      busy_d      = (state_d == ST_SHIFT) || (state_d == ST_CHECK);
      lockout_d   = (state_d == ST_LOCKOUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         parity_q    <= 1'b0;
         bit_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         fail_cnt_q  <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         load_err_q  <= 1'b0;
         lockout_q   <= 1'b0;
         ser_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         parity_q    <= parity_d;
         bit_cnt_q   <= bit_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         load_err_q  <= load_err_d;
         lockout_q   <= lockout_d;
         ser_ready_q <= ser_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign key_out   = key_q;
   assign key_valid = key_valid_q;
   assign load_err  = load_err_q;
   assign lockout   = lockout_q;
   assign ser_ready = ser_ready_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed + randomized bench for rll_key_loader against a transaction-level model
// (key accepted iff popcount(key)+parity is even; failures counted toward lockout).
`timescale 1ns/1ps

module tb_rll_key_loader;
   localparam int KEY_W    = 16;
   localparam int TIMEOUT  = 64;
   localparam int MAX_FAIL = 3;

   logic             clk = 1'b0;
   logic             rst, load_start, zeroize, ser_data, ser_valid;
   logic             ser_ready, key_valid, load_err, lockout, busy;
   logic [KEY_W-1:0] key_out;

   int checks = 0;
   int errors = 0;

   logic [KEY_W-1:0] m_key;
   logic             m_valid, m_err, m_lock;
   int               m_fails;

   rll_key_loader #(
      .KEY_W(KEY_W), .TIMEOUT(TIMEOUT), .MAX_FAIL(MAX_FAIL), .ALLOW_RELOAD(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .zeroize(zeroize),
      .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
      .key_out(key_out), .key_valid(key_valid), .load_err(load_err),
      .lockout(lockout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic bit_of(input logic [KEY_W-1:0] k, input logic p, input int i);
      return (i < KEY_W) ? k[i] : p;
   endfunction

   function automatic logic good_par(input logic [KEY_W-1:0] k);
      return ($countones(k) % 2) != 0;
   endfunction

   task automatic model_reset();
      m_key = '0; m_valid = 1'b0; m_err = 1'b0; m_lock = 1'b0; m_fails = 0;
   endtask

   task automatic model_load(input logic [KEY_W-1:0] k, input logic p);
      if ((($countones(k) + int'(p)) % 2) == 0) begin
         m_key = k; m_valid = 1'b1; m_err = 1'b0; m_fails = 0;
      end else begin
         m_fails++;
         m_key = '0; m_valid = 1'b0; m_err = 1'b1;
         m_lock = (m_fails >= MAX_FAIL);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".key_out"},   32'(key_out),   32'(m_key));
      chk({tag, ".key_valid"}, 32'(key_valid), 32'(m_valid));
      chk({tag, ".load_err"},  32'(load_err),  32'(m_err));
      chk({tag, ".lockout"},   32'(lockout),   32'(m_lock));
      chk({tag, ".busy"},      32'(busy),      32'(0));
      chk({tag, ".ser_ready"}, 32'(ser_ready), 32'(0));
   endtask

   task automatic start_load(input string tag);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk({tag, ".start_busy"},  32'(busy),      32'(1));
      chk({tag, ".start_ready"}, 32'(ser_ready), 32'(1));
      chk({tag, ".start_err"},   32'(load_err),  32'(0));
   endtask

   task automatic send_bit(input string tag, input logic b);
      ser_valid = 1'b1;
      ser_data  = b;
      chk({tag, ".ready"},       32'(ser_ready), 32'(1));
      chk({tag, ".no_partial"},  32'(key_out),   32'(0));
      tick();
      ser_valid = 1'b0;
   endtask

   task automatic finish_load(input string tag, input logic [KEY_W-1:0] k, input logic p);
      // CHECK cycle: still busy, not ready, key not yet presented
      chk({tag, ".chk_busy"},  32'(busy),      32'(1));
      chk({tag, ".chk_ready"}, 32'(ser_ready), 32'(0));
      chk({tag, ".chk_valid"}, 32'(key_valid), 32'(0));
      tick();
      model_load(k, p);
      check_outputs(tag);
   endtask

   task automatic do_load(input string tag, input logic [KEY_W-1:0] k, input logic p,
                          input int max_gap);
      start_load(tag);
      for (int i = 0; i <= KEY_W; i++) begin
         if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
         send_bit(tag, bit_of(k, p, i));
      end
      finish_load(tag, k, p);
   endtask

   task automatic do_zeroize(input string tag);
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      m_key = '0; m_valid = 1'b0; m_err = 1'b0;
      check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_outputs(tag);
   endtask

   initial begin
      logic [KEY_W-1:0] k;
      logic             p;

      rst = 1'b1; load_start = 1'b0; zeroize = 1'b0; ser_data = 1'b0; ser_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      model_reset();
      check_outputs("reset");

      // 1: clean load of 0xA5C3
      do_load("t1", 16'hA5C3, 1'b0, 0);

      // 2: bad parity, then corrected reload
      do_zeroize("t2_zero");
      do_load("t2_bad", 16'hA5C3, 1'b1, 0);
      do_load("t2_good", 16'hA5C3, 1'b0, 0);

      // 3: idle timeout, then a bit on the last idle cycle rescues the load
      do_zeroize("t3_zero");
      k = 16'h3C5A;
      start_load("t3a");
      for (int i = 0; i < 5; i++) send_bit("t3a", bit_of(k, 1'b0, i));
      repeat (TIMEOUT - 1) tick();
      chk("t3a.pre_tmo_busy", 32'(busy), 32'(1));
      chk("t3a.pre_tmo_err",  32'(load_err), 32'(0));
      tick();
      m_err = 1'b1; m_fails++;
      check_outputs("t3a.tmo");
      start_load("t3b");
      for (int i = 0; i < 5; i++) send_bit("t3b", bit_of(k, good_par(k), i));
      repeat (TIMEOUT - 1) tick();
      send_bit("t3b.late", bit_of(k, good_par(k), 5));
      chk("t3b.late_busy", 32'(busy), 32'(1));
      for (int i = 6; i <= KEY_W; i++) send_bit("t3b", bit_of(k, good_par(k), i));
      finish_load("t3b", k, good_par(k));

      // 4: three bad loads lock the block out; only rst recovers
      do_zeroize("t4_zero");
      for (int n = 0; n < MAX_FAIL; n++) begin
         k = 16'($urandom);
         do_load("t4_bad", k, ~good_par(k), 0);
      end
      chk("t4.lock_model", 32'(m_lock), 32'(1));
      load_start = 1'b1; zeroize = 1'b1; ser_valid = 1'b1; ser_data = 1'b1;
      repeat (3) tick();
      load_start = 1'b0; zeroize = 1'b0; ser_valid = 1'b0;
      check_outputs("t4.ignored");
      do_reset("t4.rst");

      // 5: load_start ignored while LOCKED; zeroize beats load_start
      k = 16'($urandom);
      do_load("t5", k, good_par(k), 0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check_outputs("t5.no_reload");
      load_start = 1'b1; zeroize = 1'b1;
      tick();
      load_start = 1'b0; zeroize = 1'b0;
      m_key = '0; m_valid = 1'b0; m_err = 1'b0;
      check_outputs("t5.zero_prio");

      // 6: reset mid-load, then a fresh load of 0x0001
      start_load("t6");
      for (int i = 0; i < 9; i++) send_bit("t6", bit_of(16'h00FF, 1'b0, i));
      ser_valid = 1'b1;
      do_reset("t6.rst");
      ser_valid = 1'b0;
      do_load("t6_fresh", 16'h0001, 1'b1, 0);

      // randomized loads with gaps; fail count persists across zeroize
      for (int n = 0; n < 24; n++) begin
         if (m_valid) do_zeroize("rnd_zero");
         k = 16'($urandom);
         p = ($urandom_range(3, 0) != 0) ? good_par(k) : ~good_par(k);
         do_load("rnd", k, p, 3);
         if (m_lock) do_reset("rnd_rst");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rll_key_loader.md
Name: rll_key_loader

Overview:
Sequential key-provisioning stage that sits directly upstream of the RLL-locked combinational netlists and drives their 16 keyIn_0_* inputs.
- Receives the key serially over a valid/ready bit stream, checks it with an even-parity bit, then latches it into a held key register.
- Presents the key only after a successful load. Until then the key bus reads all-zero.
- Includes an idle timeout, retry counting with permanent lockout, and a zeroize command.

Parameters:
KEY_W, 16, key width in bits; equals the locked netlist's key input count.
TIMEOUT, 64, max idle cycles between accepted bits in SHIFT before abort.
MAX_FAIL, 3, failed loads (parity or timeout) before permanent LOCKOUT.
ALLOW_RELOAD, 0, 1 = load_start accepted in LOCKED state.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous active-high reset.
load_start  input  1  single-cycle request to begin a key load.
zeroize  input  1  clear key and return to IDLE (ignored in LOCKOUT).
ser_data  input  1  serial key bit, LSB first, parity bit last.
ser_valid  input  1  ser_data valid.
ser_ready  output  1  loader accepts a bit this cycle.
key_out  output  KEY_W  key to the locked netlist; bit i drives keyIn_0_i.
key_valid  output  1  key_out holds a verified key.
load_err  output  1  last load failed (sticky until the next load_start or zeroize).
lockout  output  1  MAX_FAIL reached; only rst clears it.
busy  output  1  state is SHIFT or CHECK.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: key_out=0, key_valid=0, load_err=0, lockout=0, ser_ready=0, busy=0. Internal shadow, bit counter, timeout counter and fail counter are all cleared. State is IDLE.
- State set: IDLE, SHIFT, CHECK, LOCKED, ERROR, LOCKOUT. All outputs are registered.
- IDLE:
  - load_start -> SHIFT.
  - On entry to SHIFT: bit_cnt=0, shadow=0, tmo_cnt=0, load_err=0.
- SHIFT:
  - ser_ready=1.
  - A bit is accepted on an edge where ser_valid && ser_ready.
  - While bit_cnt<KEY_W: shadow[bit_cnt]<=ser_data.
  - At bit_cnt==KEY_W the accepted bit is the parity bit; it is stored and the next state is CHECK.
  - bit_cnt is wide enough to hold KEY_W and never wraps.
  - tmo_cnt resets on every accepted bit and otherwise increments.
  - When tmo_cnt reaches TIMEOUT-1 with no accept that cycle: -> ERROR.
  - load_start in SHIFT is ignored.
- CHECK (exactly one cycle, ser_ready=0):
  - If XOR of shadow and the parity bit equals 0: key_out<=shadow, key_valid<=1, -> LOCKED.
  - Otherwise: -> ERROR.
- ERROR:
  - Entry sets load_err=1 and increments fail_cnt.
  - If the incremented fail_cnt == MAX_FAIL: -> LOCKOUT instead of ERROR.
  - In ERROR, load_start -> SHIFT (retry).
- LOCKED:
  - key_out held constant.
  - load_start is ignored unless ALLOW_RELOAD=1. On reload: key_valid<=0 and key_out<=0 on the same edge, then -> SHIFT.
- LOCKOUT:
  - lockout=1, key_out=0, key_valid=0, ser_ready=0.
  - All inputs except rst are ignored.
- zeroize (any state except LOCKOUT):
  - Takes priority over load_start and over bit acceptance in the same cycle.
  - key_out<=0, key_valid<=0, load_err<=0, -> IDLE.
  - fail_cnt is NOT cleared.
- Successful load clears fail_cnt.
- Latency: the parity accept at edge N gives CHECK during cycle N..N+1. key_valid and key_out are updated at edge N+1. A full load takes KEY_W+1 handshakes plus 1 cycle.
- key_out never shows partial shadow contents.
- rst mid-load: everything returns to reset values on that edge. ser_ready=0 in the following cycle.

Test Plan:
1. Reset, load_start, then send 0xA5C3 LSB-first (16 bits) with parity 0, ser_valid held high -> ser_ready high for 17 cycles; key_out=0xA5C3 and key_valid=1 one edge after the parity accept; busy low afterwards.
2. Same key with parity 1 -> load_err=1, key_valid=0, key_out=0. Then load_start and a correct reload -> load_err=0, key_out=0xA5C3, fail counter cleared.
3. load_start, 5 bits, then ser_valid low for 64 cycles -> ERROR at timeout with load_err=1. A bit offered at cycle 63 is accepted and prevents the timeout.
4. Three consecutive bad-parity loads -> lockout=1 after the third CHECK; further load_start, zeroize and bits are ignored (ser_ready=0); only rst clears it.
5. After a successful load, assert zeroize together with load_start -> key_out=0, key_valid=0, state IDLE. Under ALLOW_RELOAD=0, load_start while LOCKED leaves key_out unchanged.
6. Assert rst after 9 bits -> all outputs reset next cycle. A fresh full load of 0x0001 (parity 1) yields key_out=0x0001, key_valid=1.
